block_uart_tx: RTL and testbench

//  Serializes a multi-byte block (default 16 bytes = 128-bit plaintext/ciphertext) onto a UART line.

---
 rtl/cb_uart_pkg.sv | 33 +++
 rtl/uart_tx_byte.sv | 112 +++++++++++
 rtl/block_uart_tx.sv | 101 ++++++++++
 tb/tb_block_uart_tx.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cb_uart_pkg.sv
// Shared definitions for the block UART transmitter.
//   FRAME_BITS : start + 8 data + parity + stop
//   DATA_BITS  : payload bits per byte
//   PARITY_ODD : 1 selects odd parity, 0 selects even
//   blk_state_t: block-level FSM states
//   tx_state_t : per-byte frame FSM states
//   odd_parity : parity bit for one data byte
package cb_uart_pkg;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;
  localparam int PARITY_ODD = 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } blk_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  // Parity bit that makes the total count of ones (data + parity) odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return (PARITY_ODD != 0) ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// One-byte UART frame serializer: start(0), d[0]..d[7], parity, stop(1).
// Each bit lasts exactly BAUD_DIV clock cycles.
// Ports:
//   clk       in   system clock, posedge
//   rst       in   synchronous active-high reset
//   send      in   request a frame; sampled when idle and in the last stop-bit cycle
//   din[7:0]  in   byte captured when a frame starts
//   tx_out    out  serial line, registered, idle high
//   byte_done out  high during the last cycle of the stop bit
//
// state     | meaning
// TX_IDLE   | line high, waiting for send
// TX_START  | driving start bit (0)
// TX_DATA   | driving data bits, LSB first
// TX_PARITY | driving parity bit
// TX_STOP   | driving stop bit (1); may chain straight into the next start bit
module uart_tx_byte
  import cb_uart_pkg::*;
#(
  parameter int BAUD_DIV = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] din,
  output logic       tx_out,
  output logic       byte_done
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int IW = $clog2(FRAME_BITS);
  localparam logic [BW-1:0] BAUD_MAX      = BW'(BAUD_DIV - 1);
  localparam logic [IW-1:0] LAST_DATA_IDX = IW'(DATA_BITS);

  tx_state_t       r_state;
  tx_state_t       w_state_nxt;
  logic [BW-1:0]   r_baud;
  logic [IW-1:0]   r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_parity;
  logic            r_tx;
  logic            w_baud_last;
  logic            w_load;
  logic            w_byte_done;
  logic            w_tx_nxt;

  assign w_baud_last = (r_baud == BAUD_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= TX_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      if (w_load) begin
        r_baud    <= '0;
        r_bit_idx <= '0;
        r_shift   <= din;
        r_parity  <= odd_parity(din);
      end else if (w_state_nxt == TX_IDLE) begin
        r_baud    <= '0;
        r_bit_idx <= '0;
      end else if (w_baud_last) begin
        r_baud    <= '0;
        r_bit_idx <= r_bit_idx + 1'b1;
        // Consume one data bit each time a data bit is placed on the line.
        if (w_state_nxt == TX_DATA) r_shift <= r_shift >> 1;
      end else begin
        r_baud <= r_baud + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      TX_IDLE:   if (send) w_state_nxt = TX_START;
      TX_START:  if (w_baud_last) w_state_nxt = TX_DATA;
      TX_DATA:   if (w_baud_last && (r_bit_idx == LAST_DATA_IDX)) w_state_nxt = TX_PARITY;
      TX_PARITY: if (w_baud_last) w_state_nxt = TX_STOP;
      TX_STOP:   if (w_baud_last) w_state_nxt = send ? TX_START : TX_IDLE;
      default:   w_state_nxt = TX_IDLE;
    endcase
  end

  // tx is computed one cycle ahead so the line itself is a plain flop.
  always_comb begin
    w_byte_done = (r_state == TX_STOP) && w_baud_last;
    w_load      = send && ((r_state == TX_IDLE) || w_byte_done);
    w_tx_nxt    = r_tx;
    if (w_load) begin
      w_tx_nxt = 1'b0;
    end else if (r_state == TX_IDLE) begin
      w_tx_nxt = 1'b1;
    end else if (w_baud_last) begin
      case (w_state_nxt)
        TX_DATA:   w_tx_nxt = r_shift[0];
        TX_PARITY: w_tx_nxt = r_parity;
        default:   w_tx_nxt = 1'b1;
      endcase
    end
  end

  assign tx_out    = r_tx;
  assign byte_done = w_byte_done;

endmodule

// File: rtl/block_uart_tx.sv
// Sends a NUM_BYTES block over UART, most significant byte first, with no
// idle gap between bytes.
// Ports:
//   clk         in   system clock, posedge
//   rst         in   synchronous active-high reset (wins over start)
//   start       in   single-cycle request, honoured only in IDLE
//   data_in     in   block to send, captured on accepted start
//   tx_out      out  serial line, registered, idle high
//   busy        out  high while the block is being sent
//   done        out  one-cycle pulse after the last stop bit
//   byte_count  out  bytes fully sent in the current or last block
//
// state | meaning
// IDLE  | line idle, waiting for start
// SEND  | byte serializer running over the latched block
// DONE  | single-cycle completion pulse
module block_uart_tx
  import cb_uart_pkg::*;
#(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200,
  parameter int NUM_BYTES     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [8*NUM_BYTES-1:0]         data_in,
  output logic                           tx_out,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(NUM_BYTES+1)-1:0] byte_count
);

  localparam int BAUD_DIV = CLK_FREQUENCY / BAUD_RATE;
  localparam int BLK_W    = 8 * NUM_BYTES;
  localparam int CW       = $clog2(NUM_BYTES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_BYTES - 1);

  blk_state_t       r_state;
  blk_state_t       w_state_nxt;
  logic [BLK_W-1:0] r_block;
  logic [BLK_W-1:0] w_block_shl;
  logic [CW-1:0]    r_count;
  logic             w_byte_done;
  logic             w_last_byte;
  logic             w_send;
  logic [7:0]       w_din;

  assign w_block_shl = r_block << 8;
  assign w_last_byte = w_byte_done && (r_count == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_block <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && start) begin
        r_block <= data_in;
        r_count <= '0;
      end else if ((r_state == SEND) && w_byte_done) begin
        r_block <= w_block_shl;
        r_count <= r_count + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = SEND;
      SEND:    if (w_last_byte) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // When a byte finishes, the serializer reloads in the same edge, so it must
  // see the byte that the shift is about to expose rather than the current one.
  always_comb begin
    busy   = (r_state == SEND);
    done   = (r_state == DONE);
    w_send = (r_state == SEND) && !w_last_byte;
    w_din  = w_byte_done ? w_block_shl[BLK_W-1 -: 8] : r_block[BLK_W-1 -: 8];
  end

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx_byte (
    .clk       (clk),
    .rst       (rst),
    .send      (w_send),
    .din       (w_din),
    .tx_out    (tx_out),
    .byte_done (w_byte_done)
  );

  assign byte_count = r_count;

endmodule

// File: tb/tb_block_uart_tx.sv
module tb_block_uart_tx;

  localparam int NB   = 16;
  localparam int BD   = 10;
  localparam int CW   = 5;
  localparam int LINE = NB * 11 * BD;

  localparam logic [127:0] B1 = 128'ha13a3ab3071897088f3233a58d6238bb;
  localparam logic [127:0] B2 = 128'h00ff01807f55aac33ce718966900f05a;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [127:0]  data_in;
  logic          tx_out;
  logic          busy;
  logic          done;
  logic [CW-1:0] byte_count;

  int total = 0;
  int bad   = 0;

  logic [127:0] rx_blk;
  logic [15:0]  rx_par;
  logic [10:0]  rx_first;
  logic [7:0]   rx_byte;
  int           line_errs;
  int           stat_errs;
  int           cnt_errs;
  int           dec_errs;
  logic         aborted;

  always #5 clk = ~clk;

  block_uart_tx #(
    .CLK_FREQUENCY (100_000),
    .BAUD_RATE     (10_000),
    .NUM_BYTES     (NB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data_in    (data_in),
    .tx_out     (tx_out),
    .busy       (busy),
    .done       (done),
    .byte_count (byte_count)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic fbit(input logic [7:0] d, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return d[j-1];
    if (j == 9) return ~^d;
    return 1'b1;
  endfunction

  task automatic idle_watch(input string tag, input int n, input logic [CW-1:0] exp_cnt);
    int errs;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (tx_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || byte_count !== exp_cnt) errs++;
    end
    check(tag, 128'(errs), 128'(0));
  endtask

  // Sends blk and checks every line cycle against a reference frame model,
  // decoding mid-bit into a left-shift register the way the receiver does.
  task automatic run_block(input string tag, input logic [127:0] blk, input int restart_at,
                           input logic [127:0] alt_data, input int rst_at);
    int b, j, c;
    logic [7:0] eb;
    data_in = blk;
    start   = 1'b1;
    step();
    start     = 1'b0;
    aborted   = 1'b0;
    line_errs = 0;
    stat_errs = 0;
    cnt_errs  = 0;
    dec_errs  = 0;
    rx_blk    = '0;
    rx_par    = '0;
    rx_first  = '0;
    rx_byte   = '0;
    check({tag, "_accept_tx"}, 128'(tx_out), 128'(1'b1));
    check({tag, "_accept_busy"}, 128'(busy), 128'(1'b1));
    for (int k = 0; k < LINE; k++) begin
      step();
      b  = k / 110;
      j  = (k % 110) / 10;
      c  = k % 10;
      eb = blk[127-8*b -: 8];
      if (tx_out !== fbit(eb, j)) line_errs++;
      if (busy !== 1'b1 || done !== 1'b0) stat_errs++;
      if (byte_count !== CW'(b)) cnt_errs++;
      if (c == 5) begin
        if (b == 0) rx_first[j] = tx_out;
        if (j == 0 && tx_out !== 1'b0) dec_errs++;
        if (j >= 1 && j <= 8) rx_byte[j-1] = tx_out;
        if (j == 9) begin
          rx_par[b] = tx_out;
          if (tx_out !== ~^rx_byte) dec_errs++;
        end
        if (j == 10) begin
          if (tx_out !== 1'b1) dec_errs++;
          rx_blk = {rx_blk[119:0], rx_byte};
        end
      end
      if (k == restart_at) begin
        start   = 1'b1;
        data_in = alt_data;
      end else begin
        start = 1'b0;
      end
      if (k == rst_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check({tag, "_rst_tx"}, 128'(tx_out), 128'(1'b1));
        check({tag, "_rst_busy"}, 128'(busy), 128'(1'b0));
        check({tag, "_rst_done"}, 128'(done), 128'(1'b0));
        check({tag, "_rst_cnt"}, 128'(byte_count), 128'(0));
        aborted = 1'b1;
        return;
      end
    end
    step();
    check({tag, "_done_pulse"}, 128'(done), 128'(1'b1));
    check({tag, "_done_busy"}, 128'(busy), 128'(1'b0));
    check({tag, "_done_tx"}, 128'(tx_out), 128'(1'b1));
    check({tag, "_done_cnt"}, 128'(byte_count), 128'(NB));
    check({tag, "_line"}, 128'(line_errs), 128'(0));
    check({tag, "_busy_run"}, 128'(stat_errs), 128'(0));
    check({tag, "_cnt_steps"}, 128'(cnt_errs), 128'(0));
    check({tag, "_decode"}, 128'(dec_errs), 128'(0));
    check({tag, "_loopback"}, rx_blk, blk);
    step();
    check({tag, "_done_once"}, 128'(done), 128'(1'b0));
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_tx", 128'(tx_out), 128'(1'b1));
    check("rst_busy", 128'(busy), 128'(1'b0));
    check("rst_done", 128'(done), 128'(1'b0));
    check("rst_cnt", 128'(byte_count), 128'(0));
    idle_watch("idle50", 50, CW'(0));

    // First frame of byte a1: start, 1,0,0,0,0,1,0,1, parity ~^a1 = 0, stop.
    run_block("blk1", B1, -1, '0, -1);
    check("blk1_first_frame", 128'(rx_first), 128'(11'b101_0100_0010));
    idle_watch("blk1_after", 30, CW'(NB));

    run_block("blk2", B2, -1, '0, -1);
    check("par_00", 128'(rx_par[0]), 128'(1'b1));
    check("par_ff", 128'(rx_par[1]), 128'(1'b1));
    check("par_01", 128'(rx_par[2]), 128'(1'b0));

    // Restart request and new data during byte 3 must not disturb the block.
    run_block("blk3", B1, 2*110 + 30, ~B1, -1);
    idle_watch("blk3_no_extra", 200, CW'(NB));

    // Reset inside byte 5's data bits, then a clean block.
    run_block("blk4", B2, -1, '0, 4*110 + 35);
    check("blk4_aborted", 128'(aborted), 128'(1'b1));
    idle_watch("blk4_after_rst", 20, CW'(0));
    run_block("blk5", B1, -1, '0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
